// File: rtl/ladybird_uart_loader_pkg.sv
// Shared types and constants for the ladybird UART boot loader and its receiver.
package ladybird_uart_loader_pkg;

    localparam int XLEN           = 32;
    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        S_LEN  = 2'd0,
        S_DATA = 2'd1,
        S_DONE = 2'd2
    } loader_state_e;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_HIGH = 3'd4
    } rx_state_e;

    // Little-endian assembly: newest byte enters at the top and older bytes shift down.
    function automatic logic [31:0] assemble_byte(input logic [31:0] shreg,
                                                  input logic [UART_DATA_BITS-1:0] rx_byte);
        return {rx_byte, shreg[31:UART_DATA_BITS]};
    endfunction

endpackage

// File: rtl/ladybird_bus.sv
// Instruction-bus port shared by the core fetch unit and the boot loader.
interface ladybird_bus;

    logic                                   req;
    logic [ladybird_uart_loader_pkg::XLEN-1:0] addr;
    logic [3:0]                             wstrb;
    logic [31:0]                            data;
    logic                                   gnt;

    modport primary (output req, addr, wstrb, data, input gnt);
    modport arbiter (input req, addr, wstrb, data, output gnt);

endinterface

// File: rtl/ladybird_uart_rx.sv
// 8N1 UART receiver with a 2-flop synchronizer; one-cycle valid and frame-error pulses.
module ladybird_uart_rx
    import ladybird_uart_loader_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = 868
)(
    input  logic                      clk,
    input  logic                      arst,
    input  logic                      rx,
    output logic                      rx_valid,
    output logic [UART_DATA_BITS-1:0] rx_byte,
    output logic                      frame_err_pulse
);

    localparam int CNT_W = $clog2(CLK_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLK_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

    rx_state_e                 state_q, state_d;
    logic                      meta_q, sync_q, prev_q;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [2:0]                bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      valid_q, valid_d;
    logic                      ferr_q, ferr_d;

    // Next-state logic for the bit-timing state machine.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!sync_q && prev_q) begin
                    state_d = RX_START;
                end else begin
                    state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    // A start bit that has gone high again was a glitch.
                    if (!sync_q) begin
                        state_d = RX_DATA;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end else begin
                    state_d = RX_START;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {sync_q, shift_q[UART_DATA_BITS-1:1]};
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    state_d = RX_DATA;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (sync_q) begin
                        valid_d = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = RX_WAIT_HIGH;
                    end
                end else begin
                    state_d = RX_STOP;
                end
            end
            RX_WAIT_HIGH: begin
                cnt_d = '0;
                if (sync_q) begin
                    state_d = RX_IDLE;
                end else begin
                    state_d = RX_WAIT_HIGH;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = RX_IDLE;
            end
        endcase
    end

    // Synchronizer and receiver state registers; the line resets to its idle-high level.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            meta_q    <= 1'b1;
            sync_q    <= 1'b1;
            prev_q    <= 1'b1;
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            meta_q    <= rx;
            sync_q    <= meta_q;
            prev_q    <= sync_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    assign rx_valid        = valid_q;
    assign rx_byte         = shift_q;
    assign frame_err_pulse = ferr_q;

endmodule

// File: rtl/ladybird_uart_loader.sv
// UART boot loader: length-prefixed image received over 8N1 and written word-by-word to IRAM.
module ladybird_uart_loader
    import ladybird_uart_loader_pkg::*;
#(
    parameter int unsigned     CLK_PER_BIT = 868,
    parameter logic [XLEN-1:0] BASE_ADDR   = '0,
    parameter int unsigned     ADDR_W      = XLEN
)(
    input  logic           clk,
    input  logic           arst,
    input  logic           uart_rx,
    ladybird_bus.primary   bus,
    output logic           busy,
    output logic           done,
    output logic           frame_err,
    output logic           overrun_err
);

    logic                      rx_valid_s;
    logic [UART_DATA_BITS-1:0] rx_byte_s;
    logic                      frame_err_pulse_s;

    ladybird_uart_rx #(
        .CLK_PER_BIT (CLK_PER_BIT)
    ) u_rx (
        .clk             (clk),
        .arst            (arst),
        .rx              (uart_rx),
        .rx_valid        (rx_valid_s),
        .rx_byte         (rx_byte_s),
        .frame_err_pulse (frame_err_pulse_s)
    );

    loader_state_e     state_q, state_d;
    logic              ln_meta_q, ln_sync_q;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       shreg_q, shreg_d;
    logic [31:0]       remaining_q, remaining_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              req_q, req_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [31:0]       data_q, data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_err_q, overrun_err_d;

    logic [31:0]       word_s;
    logic              word_done_s;
    logic              grant_s;

    assign word_s      = assemble_byte(shreg_q, rx_byte_s);
    assign word_done_s = rx_valid_s && (byte_cnt_q == 2'd3) && (state_q != S_DONE);
    assign grant_s     = req_q && bus.gnt;

    // Assembly register, loader FSM, address counter and bus-driver next state.
    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        shreg_d       = shreg_q;
        remaining_d   = remaining_q;
        addr_d        = addr_q;
        req_d         = req_q;
        wstrb_d       = wstrb_q;
        data_d        = data_q;
        busy_d        = busy_q;
        done_d        = done_q;
        frame_err_d   = frame_err_q;
        overrun_err_d = overrun_err_q;

        if (rx_valid_s && (state_q != S_DONE)) begin
            shreg_d    = word_s;
            byte_cnt_d = byte_cnt_q + 2'd1;
        end else begin
            shreg_d    = shreg_q;
            byte_cnt_d = byte_cnt_q;
        end

        if (frame_err_pulse_s) begin
            frame_err_d = 1'b1;
        end else begin
            frame_err_d = frame_err_q;
        end

        case (state_q)
            S_LEN: begin
                // The line only goes low for a start bit once the loader is out of reset.
                if (!ln_sync_q) begin
                    busy_d = 1'b1;
                end else begin
                    busy_d = busy_q;
                end
                if (word_done_s) begin
                    if (word_s == 32'd0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d     = S_DATA;
                        remaining_d = word_s;
                        addr_d      = ADDR_W'(BASE_ADDR);
                        busy_d      = 1'b1;
                    end
                end else begin
                    state_d = S_LEN;
                end
            end
            S_DATA: begin
                if (grant_s) begin
                    req_d       = 1'b0;
                    addr_d      = addr_q + ADDR_W'(32'd4);
                    remaining_d = remaining_q - 32'd1;
                    if (remaining_q == 32'd1) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
                // A word arriving before the previous grant is dropped; the pending write stays intact.
                if (word_done_s) begin
                    if (req_q) begin
                        overrun_err_d = 1'b1;
                    end else begin
                        data_d  = word_s;
                        wstrb_d = 4'hF;
                        req_d   = 1'b1;
                    end
                end else begin
                    overrun_err_d = overrun_err_q;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
                req_d   = 1'b0;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_LEN;
                req_d   = 1'b0;
            end
        endcase
    end

    // Loader state and registered outputs; asynchronous reset drops req immediately.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q       <= S_LEN;
            ln_meta_q     <= 1'b1;
            ln_sync_q     <= 1'b1;
            byte_cnt_q    <= 2'd0;
            shreg_q       <= 32'd0;
            remaining_q   <= 32'd0;
            addr_q        <= '0;
            req_q         <= 1'b0;
            wstrb_q       <= 4'h0;
            data_q        <= 32'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ln_meta_q     <= uart_rx;
            ln_sync_q     <= ln_meta_q;
            byte_cnt_q    <= byte_cnt_d;
            shreg_q       <= shreg_d;
            remaining_q   <= remaining_d;
            addr_q        <= addr_d;
            req_q         <= req_d;
            wstrb_q       <= wstrb_d;
            data_q        <= data_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            frame_err_q   <= frame_err_d;
            overrun_err_q <= overrun_err_d;
        end
    end

    assign bus.req     = req_q;
    assign bus.addr    = XLEN'(addr_q);
    assign bus.wstrb   = wstrb_q;
    assign bus.data    = data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_err_q;

endmodule
